// File: rtl/hex_scroller.sv
// Scrolling message display: a small character buffer is shown through a
// NUM_DIGITS-wide window on active-low 7-segment digits, moved one place per tick period.

module hex_seg_dec (
    input  logic [2:0] code,
    output logic [6:0] seg_n
);
    // seg_n[0] = segment a ... seg_n[6] = segment g, active-low
    always_comb begin
        seg_n = 7'h7F;
        case (code)
            3'd0:    seg_n = 7'b0001001;
            3'd1:    seg_n = 7'b0000110;
            3'd2:    seg_n = 7'b1000111;
            3'd3:    seg_n = 7'b1000000;
            default: seg_n = 7'h7F;
        endcase
    end
endmodule

module hex_scroller #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Run,
    input  logic                    Dir,
    input  logic                    Load,
    input  logic [3:0]              LoadAddr,
    input  logic [2:0]              LoadChar,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    Step
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(MSG_LEN);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(MSG_LEN - 1);

    logic [MSG_LEN-1:0][2:0]    msg_q, msg_d;
    logic [PW-1:0]              pos_q, pos_d;
    logic [TW-1:0]              tick_q, tick_d;
    logic                       step_q, step_d;
    logic [7*NUM_DIGITS-1:0]    hex_q, hex_d;

    logic [NUM_DIGITS-1:0][2:0] dig_char;
    logic [NUM_DIGITS-1:0][6:0] dig_seg;

    always_comb begin
        tick_d = tick_q;
        pos_d  = pos_q;
        step_d = 1'b0;
        msg_d  = msg_q;
        if (Run) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                step_d = 1'b1;
                if (Dir)
                    pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
                else
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
        // out-of-range addresses match no entry and are dropped
        for (int i = 0; i < MSG_LEN; i++)
            if (Load && LoadAddr == 4'(i))
                msg_d[i] = LoadChar;
    end

    // leftmost digit shows msg[pos], wrapping around the buffer
    always_comb begin
        dig_char = '0;
        for (int j = 0; j < NUM_DIGITS; j++)
            for (int i = 0; i < MSG_LEN; i++)
                if (((int'(pos_q) + j) % MSG_LEN) == i)
                    dig_char[NUM_DIGITS-1-j] = msg_q[i];
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        hex_seg_dec u_dec (
            .code  (dig_char[k]),
            .seg_n (dig_seg[k])
        );
    end

    assign hex_d = dig_seg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pos_q  <= '0;
            tick_q <= '0;
            step_q <= 1'b0;
            hex_q  <= '1;
            for (int i = 0; i < MSG_LEN; i++)
                msg_q[i] <= (i < 4) ? 3'(i) : 3'd4;
        end else begin
            pos_q  <= pos_d;
            tick_q <= tick_d;
            step_q <= step_d;
            hex_q  <= hex_d;
            msg_q  <= msg_d;
        end
    end

    assign HEX  = hex_q;
    assign Step = step_q;
endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller with NUM_DIGITS=4, MSG_LEN=8, TICK_DIV=4.

module tb_hex_scroller;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        Dir = 1'b0;
    logic        Load = 1'b0;
    logic [3:0]  LoadAddr = '0;
    logic [2:0]  LoadChar = '0;
    logic [27:0] HEX;
    logic        Step;

    int errs = 0;
    int checks = 0;
    int em [0:7];
    int p;

    localparam int H = 0, E = 1, L = 2, O = 3, B = 4;

    hex_scroller #(.NUM_DIGITS(4), .MSG_LEN(8), .TICK_DIV(4)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Dir(Dir), .Load(Load),
        .LoadAddr(LoadAddr), .LoadChar(LoadChar), .HEX(HEX), .Step(Step)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // segment strings written a..g left to right, as in the datasheet table
    function automatic logic [6:0] seg(input int c);
        logic [6:0] s, r;
        case (c)
            H: s = 7'b1001000;
            E: s = 7'b0110000;
            L: s = 7'b1110001;
            O: s = 7'b0000001;
            default: s = 7'b1111111;
        endcase
        for (int i = 0; i < 7; i++) r[i] = s[6-i];
        return r;
    endfunction

    function automatic logic [31:0] hx(input int c3, input int c2, input int c1, input int c0);
        return {4'h0, seg(c3), seg(c2), seg(c1), seg(c0)};
    endfunction

    function automatic logic [31:0] view(input int pp);
        return hx(em[pp], em[(pp+1)%8], em[(pp+2)%8], em[(pp+3)%8]);
    endfunction

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        chk("rst_hex", 32'(HEX), 32'h0FFF_FFFF);
        chk("rst_step", 32'(Step), 0);
        Reset = 1'b0;
        em = '{H, E, L, O, B, B, B, B};
        p = 0;
    endtask

    initial begin
        int prev;
        @(negedge Clock);

        // pause after reset: HELO constant, no steps
        Run = 1'b0;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            cyc();
            chk("pause_hex", 32'(HEX), hx(H, E, L, O));
            chk("pause_step", 32'(Step), 0);
        end

        // scroll left through a full lap
        Run = 1'b1; Dir = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            cyc();
            prev = p;
            chk("left_step", 32'(Step), 32'((n % 4) == 0));
            chk("left_hex", 32'(HEX), view(prev));
            if ((n % 4) == 0) p = (p + 1) % 8;
            if (n == 5)  chk("left_first", 32'(HEX), hx(E, L, O, B));
            if (n == 33) chk("left_wrap", 32'(HEX), hx(H, E, L, O));
        end

        // scroll right from reset: Pos wraps to 7
        Dir = 1'b1;
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            cyc();
            chk("right_step", 32'(Step), 32'(n == 4));
        end
        cyc();
        chk("right_hex", 32'(HEX), hx(B, H, E, L));

        // load coinciding with a step, then ignored and paused writes
        Dir = 1'b0;
        do_reset();
        for (int n = 1; n <= 3; n++) cyc();
        Load = 1'b1; LoadAddr = 4'd4; LoadChar = 3'd0;
        cyc();
        chk("ld_step", 32'(Step), 1);
        Load = 1'b0;
        cyc();
        chk("ld_hex", 32'(HEX), hx(E, L, O, H));
        Run = 1'b0;
        Load = 1'b1; LoadAddr = 4'd9; LoadChar = 3'd0;
        cyc();
        Load = 1'b0;
        for (int n = 0; n < 2; n++) begin
            cyc();
            chk("ld_oob", 32'(HEX), hx(E, L, O, H));
        end
        Load = 1'b1; LoadAddr = 4'd2; LoadChar = 3'd3;
        cyc();
        Load = 1'b0;
        cyc();
        chk("ld_pause", 32'(HEX), hx(E, O, O, H));

        // pause at count 2, resume continues from held count
        Run = 1'b1;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            cyc();
            chk("hold_pre", 32'(Step), 0);
        end
        Run = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("hold_step", 32'(Step), 0);
            chk("hold_hex", 32'(HEX), hx(H, E, L, O));
        end
        Run = 1'b1;
        cyc();
        chk("resume_1", 32'(Step), 0);
        cyc();
        chk("resume_2", 32'(Step), 1);
        cyc();
        chk("resume_hex", 32'(HEX), hx(E, L, O, B));

        // reset mid-count with a simultaneous load that must be discarded
        cyc();
        Load = 1'b1; LoadAddr = 4'd0; LoadChar = 3'd3;
        do_reset();
        Load = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            cyc();
            chk("mid_step", 32'(Step), 32'(n == 4));
            if (n == 1) chk("mid_hex", 32'(HEX), hx(H, E, L, O));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/hex_scroller.md
HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of 7-segment digits driven, legal range 1..8.
REQ-002 SHALL have parameter MSG_LEN, default 8: message buffer depth in characters, legal range 4..16.
REQ-003 SHALL have parameter TICK_DIV, default 25000000: Clock cycles per scroll step, legal minimum 2.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Run, input, 1 bit: 1 = scroll, 0 = pause.
REQ-007 SHALL have port Dir, input, 1 bit: 0 = scroll left (Pos increments), 1 = scroll right (Pos decrements).
REQ-008 SHALL have port Load, input, 1 bit: write strobe for the message buffer.
REQ-009 SHALL have port LoadAddr, input, 4 bits: buffer index to write.
REQ-010 SHALL have port LoadChar, input, 3 bits: character code, 0=H, 1=E, 2=L, 3=O, 4..7=blank.
REQ-011 SHALL have port HEX, output, 7*NUM_DIGITS bits: active-low segments; digit k occupies bits 7k..7k+6, with bit 7k = segment a through bit 7k+6 = segment g.
REQ-012 SHALL have port Step, output, 1 bit: one-cycle pulse marking a Pos change.

Function
REQ-013 SHALL decode each character to segments a..g, active-low, as follows: H=1001000, E=0110000, L=1110001, O=0000001, blank=1111111.
REQ-014 SHALL hold a MSG_LEN-entry buffer of 3-bit codes, a scroll pointer Pos in 0..MSG_LEN-1, and a tick counter in 0..TICK_DIV-1.
REQ-015 SHALL map digit NUM_DIGITS-1-j, for j = 0..NUM_DIGITS-1, to buffer[(Pos+j) mod MSG_LEN], so the leftmost digit shows buffer[Pos].
REQ-016 SHALL register HEX, so that HEX reflects the Pos and buffer contents of the previous cycle (latency 1).
REQ-017 SHALL, while Run=1, increment the tick counter each cycle; on the cycle it equals TICK_DIV-1 it SHALL return to 0 and Pos SHALL step.
REQ-018 SHALL, while Run=0, hold both the tick counter and Pos, with Step=0; on resuming Run=1, counting SHALL continue from the held count.
REQ-019 SHALL step Pos as follows: Dir=0 gives Pos+1, with MSG_LEN-1 wrapping to 0; Dir=1 gives Pos-1, with 0 wrapping to MSG_LEN-1; Dir SHALL be sampled on the step cycle only.
REQ-020 SHALL assert Step for exactly one cycle, the same cycle the new Pos value is visible, and SHALL otherwise hold Step at 0.
REQ-021 SHALL, when Load=1 and LoadAddr<MSG_LEN, write LoadChar into buffer[LoadAddr] at the clock edge; when LoadAddr>=MSG_LEN, the write SHALL be ignored with no state change.
REQ-022 SHALL, when a Load and a step occur in the same cycle, perform both; the HEX value one cycle later SHALL reflect both the new Pos and the new character.
REQ-023 SHALL leave Pos and the tick counter unaffected by Load; a pause SHALL leave the buffer writable.
REQ-024 SHALL keep the first step after reset with Run held at 1 exactly TICK_DIV cycles after Reset deasserts.

Reset
REQ-025 SHALL, on Reset=1 at a clock edge, set Pos=0, tick counter=0, Step=0, and HEX to all ones (all digits blank).
REQ-026 SHALL, on reset, load buffer[0..3]=H,E,L,O and buffer[4..MSG_LEN-1]=blank.
REQ-027 SHALL give Reset priority over Run and Load in the same cycle, including reset mid-count or mid-write; the Load in that cycle SHALL be discarded.
REQ-028 SHALL show H,E,L,O on digits 3..0 (with default parameters) on the first cycle after Reset deasserts.

Verification (NUM_DIGITS=4, MSG_LEN=8, TICK_DIV=4)
REQ-029 SHALL cover reset then Run=0 for 10 cycles -> digits 3..0 = 1001000, 0110000, 1110001, 0000001 constant; Step never asserted.
REQ-030 SHALL cover Run=1, Dir=0 -> Step pulses on cycles 4, 8, 12...; after the first step, digits 3..0 show E, L, O, blank; after 8 steps Pos=0 and HELO is shown again.
REQ-031 SHALL cover Run=1, Dir=1 from reset -> the first step gives Pos=7 and digits 3..0 show blank, H, E, L.
REQ-032 SHALL cover Load with LoadAddr=4, LoadChar=0 coinciding with a step (Dir=0) -> the next cycle shows E, L, O, H; Load with LoadAddr=9 changes nothing.
REQ-033 SHALL cover Run dropped at count 2 for 5 cycles, then raised -> the step occurs 1 cycle after resume; Reset asserted mid-count -> Pos=0, all digits blank, then HELO.
